// File: rtl/core_pkg.sv
// Shared core constants and helpers used by the pipeline buffering blocks.
package core_pkg;

  localparam int DATA_W  = 32;
  localparam int SHIFT_M = 3;

  // Pointer width for a storage array of the given depth. This is never less than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for a small FIFO.
// It has one synchronous write port and one asynchronous read port.
// The contents are deliberately left unreset.
module fifo_mem
  import core_pkg::*;
#(
  parameter int N     = DATA_W,
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [ptr_width(DEPTH)-1:0] waddr,
  input  logic [N-1:0]                wdata,
  input  logic [ptr_width(DEPTH)-1:0] raddr,
  output logic [N-1:0]                rdata
);

  logic [N-1:0] mem [DEPTH];

  // Write the addressed entry on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/delay_skid_fifo.sv
// Skid buffer behind the fixed-latency delay line.
// It absorbs entries that cannot be stalled.
// almost_full warns the upstream issue logic early enough that in-flight entries still fit.
module delay_skid_fifo
  import core_pkg::*;
#(
  parameter int N            = DATA_W,
  parameter int DEPTH        = 8,
  parameter int AFULL_MARGIN = SHIFT_M
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [N-1:0]           in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full,
  output logic                   overflow,
  input  logic                   clr_ovf,
  input  logic                   flush
);

  localparam int PW   = ptr_width(DEPTH);
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int AF_T = (DEPTH > AFULL_MARGIN) ? DEPTH - AFULL_MARGIN : 0;
  localparam logic [CW-1:0] AF_THRESH = CW'(AF_T);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop;
  logic          full;
  logic          accept;
  logic          drop;

  assign out_valid   = (count != '0);
  assign almost_full = (count >= AF_THRESH);
  assign full        = (count == FULL_CNT);
  assign pop         = out_valid & out_ready;
  assign accept      = in_valid & (~full | pop);
  assign drop        = in_valid & full & ~pop & ~flush;

  fifo_mem #(
    .N    (N),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (accept & ~flush),
    .waddr(wr_ptr),
    .wdata(in_data),
    .raddr(rd_ptr),
    .rdata(out_data)
  );

  // Advance the pointers and track occupancy. A flush takes priority over any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Latch an overflow on a dropped entry. A drop beats a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: doc/delay_skid_fifo.md
Name: delay_skid_fifo

Overview:
Receives the output of the fixed-latency delay line (`shift`) and buffers it for a consumer that can stall. The delay line cannot be stalled, so this block absorbs up to DEPTH entries. It also warns the upstream issue logic with almost_full early enough that the M in-flight entries still fit. Used on writeback-tag and result paths in the core.

Parameters:
N, 32, data width (matches shift N)
DEPTH, 8, number of entries; power of 2, >= 2
AFULL_MARGIN, 3, in-flight allowance (equals shift M); almost_full asserts when count >= DEPTH - AFULL_MARGIN

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  entry present on in_data this cycle; no backpressure (no in_ready)
in_data  in  N  data from delay line output
out_valid  out  1  FIFO non-empty; out_data valid
out_ready  in  1  consumer accepts head entry this cycle
out_data  out  N  head entry
count  out  $clog2(DEPTH)+1  current occupancy 0..DEPTH
almost_full  out  1  count >= DEPTH - AFULL_MARGIN
overflow  out  1  sticky: an entry was dropped
clr_ovf  in  1  clears overflow
flush  in  1  synchronous discard of all entries

Behaviour:
- Reset (rst_n=0, async): wr_ptr=0, rd_ptr=0, count=0, overflow=0. As a result out_valid=0 and almost_full=0 (if DEPTH-AFULL_MARGIN>0). The storage array is not reset.
- push = in_valid; pop = out_valid & out_ready. A pop while empty has no effect.
- Latency: no bypass. An entry written at edge k is visible on out_data/out_valid after edge k (a 1-cycle minimum from in_valid to out_valid).
- out_valid = (count != 0). out_data = mem[rd_ptr], combinational read. out_data is undefined while out_valid=0, and the bench must not check it then.
- Push when not full: mem[wr_ptr] <= in_data; wr_ptr increments and wraps modulo DEPTH.
- Pop: rd_ptr increments and wraps modulo DEPTH.
- Push and pop in the same cycle:
  - Both take effect and count is unchanged.
  - This holds when full: the pop frees the slot and the push is accepted.
  - This holds when count=1: the new entry becomes the head next cycle.
- Push when full without pop: the entry is dropped, pointers and count are unchanged, and overflow <= 1.
- count: +1 on accepted push only, -1 on pop only, unchanged otherwise. It never exceeds DEPTH and never underflows.
- flush=1: next state is wr_ptr=rd_ptr=0, count=0. A flush overrides any push or pop in the same cycle, and in_data that cycle is discarded without setting overflow.
- overflow: set by a drop; cleared by clr_ovf. If a set and clr_ovf occur in the same cycle, set wins. flush does not clear overflow.
- almost_full and out_valid are combinational from registered count only; there is no path from in_valid or out_ready to any output.
- Reset asserted mid-operation clears all state immediately; contents are lost.

Decomposition:
- Shared package core_pkg: DATA_W=32, default SHIFT_M=3, and a constant function for pointer width ($clog2).
- One sub-module fifo_mem: DEPTH x N register array, one write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata), with no reset.
- Pointer, count and flag logic stays in delay_skid_fifo.

Test Plan:
- Reset then idle: after rst_n deasserts, out_valid=0, count=0, almost_full=0, overflow=0.
- Push 0xA1, 0xB2, 0xC3 on consecutive cycles with out_ready=0, then hold out_ready=1:
  - count reaches 3 with no almost_full (threshold 5);
  - out_data sequence is 0xA1, 0xB2, 0xC3;
  - out_valid drops the cycle after the third pop.
- Fill to 5 entries -> almost_full=1 exactly when count=5. Continue to 8 entries, then push 0xDEAD with out_ready=0 -> count stays 8, overflow=1, 0xDEAD never appears on out_data.
- With FIFO full, push 0x55 and pop together -> count stays 8. After draining, 0x55 is the last entry out, which checks pointer wrap.
- flush asserted at count=6 together with in_valid=1 -> next cycle count=0 and out_valid=0, and overflow is unchanged. Then assert clr_ovf with a simultaneous drop -> overflow stays 1; clr_ovf alone -> overflow=0.
- Assert rst_n=0 asynchronously between clock edges at count=4 -> count=0 and out_valid=0 before the next edge, and a push after release is accepted.
